// File: rtl/mult_pipe_td.sv
// Retimed WIDTH x WIDTH multiplier with valid/ready handshakes, per-beat signed
// and accumulate modes. product1 is both the output register and the accumulator.
module mult_pipe_td #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     mx,
    input  logic [WIDTH-1:0]     my,
    input  logic                 op_signed,
    input  logic                 op_acc,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   product1,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int PW = 2 * WIDTH;

    logic              stall;
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:0]   acc_pipe;
    logic [WIDTH-1:0]  x0, y0;
    logic              sgn0;
    logic [PW-1:0]     xe, ye;
    logic [PW-1:0]     prod_pipe [1:STAGES];

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    assign xe = sgn0 ? {{WIDTH{x0[WIDTH-1]}}, x0} : {{WIDTH{1'b0}}, x0};
    assign ye = sgn0 ? {{WIDTH{y0[WIDTH-1]}}, y0} : {{WIDTH{1'b0}}, y0};

    // Control bits: bubbles shift like data, so a reset only needs to clear valids.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_pipe <= '0;
            acc_pipe <= '0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
            acc_pipe <= {acc_pipe[STAGES-1:0], op_acc};
        end
    end

    // Datapath: full product formed in stage 1, later stages give the tools room to retime.
    always_ff @(posedge CLK) begin
        if (!stall) begin
            x0           <= mx;
            y0           <= my;
            sgn0         <= op_signed;
            prod_pipe[1] <= xe * ye;
            for (int i = 2; i <= STAGES; i++)
                prod_pipe[i] <= prod_pipe[i-1];
        end
    end

    // A bubble at the end of the pipe drops out_valid but leaves the accumulator alone.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            product1  <= '0;
        end else if (!stall) begin
            out_valid <= vld_pipe[STAGES];
            if (vld_pipe[STAGES])
                product1 <= acc_pipe[STAGES] ? product1 + prod_pipe[STAGES] : prod_pipe[STAGES];
        end
    end
endmodule

// File: tb/tb_mult_pipe_td.sv
// Directed bench for mult_pipe_td: latency, signed/unsigned, accumulate, backpressure,
// random handshake stress and mid-stream reset, checked with immediate assertions.
module tb_mult_pipe_td;
    localparam int W = 32;
    localparam int S = 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic [W-1:0]    mx, my;
    logic            op_signed, op_acc, in_valid, in_ready;
    logic [2*W-1:0]  product1;
    logic            out_valid, out_ready;

    always #5 CLK = ~CLK;

    mult_pipe_td #(.WIDTH(W), .STAGES(S)) dut (
        .CLK(CLK), .RST(RST), .mx(mx), .my(my), .op_signed(op_signed), .op_acc(op_acc),
        .in_valid(in_valid), .in_ready(in_ready), .product1(product1),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    int          passed = 0;
    int          total  = 0;
    int          ndeliv = 0;
    bit          use_model = 0;
    bit          last_acc;
    logic [63:0] cur_exp;
    logic [63:0] model_last = '0;
    logic [63:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic s, input logic a, input logic [63:0] last);
        logic [63:0] ex, ey, p;
        ex = s ? {{32{x[31]}}, x} : {32'b0, x};
        ey = s ? {{32{y[31]}}, y} : {32'b0, y};
        p  = ex * ey;
        return a ? last + p : p;
    endfunction

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input logic a, input logic v, input logic [63:0] e);
        mx = x; my = y; op_signed = s; op_acc = a; in_valid = v; cur_exp = e;
    endtask

    // One clock: settle, score the handshakes that will fire on this edge, then advance.
    task automatic tick();
        logic [63:0] e;
        #1;
        last_acc = 1'b0;
        if (!RST) begin
            chk("in_ready", {63'b0, in_ready}, {63'b0, ~(out_valid & ~out_ready)});
            if (in_valid && in_ready) begin
                e = use_model ? model(mx, my, op_signed, op_acc, model_last) : cur_exp;
                exp_q.push_back(e);
                model_last = e;
                last_acc = 1'b1;
            end
            if (out_valid && out_ready) begin
                ndeliv++;
                if (exp_q.size() == 0) chk("spurious_out", {63'b0, out_valid}, 64'd0);
                else chk("result", product1, exp_q.pop_front());
            end
        end
        @(posedge CLK);
        #1;
        if (RST) begin
            exp_q.delete();
            model_last = '0;
        end
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        int n0, idx, acc_cnt, cyc;
        RST = 1'b1; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick();
        RST = 1'b0;
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_product1", product1, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

        // Latency: accept at edge k, out_valid first high after edge k+3
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 64'hFFFFFFFE00000001);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("lat_valid", {63'b0, out_valid}, {63'b0, (i == 3)});
        end
        chk("lat_product", product1, 64'hFFFFFFFE00000001);
        idle(2);

        // Signed back-to-back
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1, 64'h0000000000000001); tick();
        drive(32'h80000000, 32'h80000000, 1, 0, 1, 64'h4000000000000000); tick();
        drive(32'hFFFFFFFF, 32'd2,        1, 0, 1, 64'hFFFFFFFFFFFFFFFE); tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b2b_valid", {63'b0, out_valid}, {63'b0, (i < 3)});
        end

        // Accumulate wrap, then chain 12/42/98
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 64'hFFFFFFFE00000001); tick();
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 1, 64'hFFFFFFFC00000002); tick();
        drive(3, 4, 0, 0, 1, 64'd12); tick();
        drive(5, 6, 0, 1, 1, 64'd42); tick();
        drive(7, 8, 0, 1, 1, 64'd98); tick();
        idle(6);
        chk("acc_hold_valid", {63'b0, out_valid}, 64'd0);
        chk("acc_hold_98", product1, 64'd98);

        // Backpressure: out_ready low for cycles 4..9
        n0 = ndeliv; idx = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 4 && c <= 9);
            if (idx < 6) drive(idx + 1, idx + 1, 0, 0, 1, 64'((idx + 1) * (idx + 1)));
            else drive(0, 0, 0, 0, 0, 0);
            tick();
            if (last_acc) idx++;
        end
        chk("bp_count", 64'(ndeliv - n0), 64'd6);

        // Random out_ready with a continuous stream, scored by the model
        use_model = 1; n0 = ndeliv; acc_cnt = 0; cyc = 0;
        while (acc_cnt < 200 && cyc < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0);
            tick();
            if (last_acc) acc_cnt++;
            cyc++;
        end
        out_ready = 1'b1;
        idle(8);
        chk("rand_count", 64'(ndeliv - n0), 64'd200);
        use_model = 0;

        // Reset with two beats in flight and product1 = 98
        drive(3, 4, 0, 0, 1, 64'd12); tick();
        drive(5, 6, 0, 1, 1, 64'd42); tick();
        drive(7, 8, 0, 1, 1, 64'd98); tick();
        idle(6);
        chk("pre_rst_98", product1, 64'd98);
        drive(1, 1, 0, 0, 1, 64'd1); tick();
        drive(2, 2, 0, 0, 1, 64'd4); tick();
        n0 = ndeliv;
        RST = 1'b1;
        drive(9, 9, 0, 0, 1, 64'd81);
        tick();
        RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("post_rst_valid", {63'b0, out_valid}, 64'd0);
        chk("post_rst_product1", product1, 64'd0);
        chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("flushed_valid", {63'b0, out_valid}, 64'd0);
        end
        chk("flushed_count", 64'(ndeliv - n0), 64'd0);
        drive(2, 3, 0, 1, 1, 64'd6); tick();
        idle(3);
        chk("rst_acc_6", product1, 64'd6);
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mult_pipe_td.md
Name: mult_pipe_td

Overview:
- Parametrised successor of the fixed 32-bit registered-multiplier timing driver.
- Multiplies two WIDTH-bit operands through a STAGES-deep retimed pipeline with valid/ready handshakes on input and output.
- Supports signed/unsigned mode and a multiply-accumulate mode, selected per transaction.
- Sits between an operand source (FIFO or datapath) and a result consumer that may apply backpressure.

Parameters:
- WIDTH, 32, operand width in bits; product and accumulator are 2*WIDTH bits.
- STAGES, 2, number of product-pipeline register stages after input capture; legal range 1..8.

Ports:
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  synchronous, active-high reset
- mx  input  WIDTH  multiplicand
- my  input  WIDTH  multiplier
- op_signed  input  1  1 = two's-complement operands, 0 = unsigned
- op_acc  input  1  1 = add product to the previous result (accumulate), 0 = plain product
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- product1  output  2*WIDTH  result (product or accumulated sum)
- out_valid  output  1  product1 valid
- out_ready  input  1  consumer accepts product1 this cycle

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: all stage valid bits 0, out_valid 0, product1 0, accumulator 0. Data registers other than product1 are don't-care.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - When stall is high, every pipeline register, including input capture and output, holds.
  - When stall is low, the whole pipe advances one stage per cycle. Bubbles (valid=0) advance like data.
- Accept: a beat is accepted on an edge where in_valid & in_ready. mx, my, op_signed and op_acc are captured together into stage 0.
- Latency: the accepted beat appears with out_valid=1 exactly STAGES+1 edges after the accepting edge, provided no stall occurs. Each stall cycle adds one cycle. Throughput is 1 beat/cycle without backpressure.
- Arithmetic:
  - Operands are extended to 2*WIDTH bits: sign-extended if op_signed=1, zero-extended otherwise.
  - The product is taken modulo 2^(2*WIDTH). Partial-product/adder work may be distributed across stages 1..STAGES in any form; only stage boundaries and latency are fixed.
  - op_signed and op_acc travel with the data through the pipe.
- Output register (product1 doubles as the accumulator):
  - On an edge where the final stage holds a valid beat and stall is low:
    - if op_acc=0: product1 <= product
    - if op_acc=1: product1 <= product1 + product (mod 2^(2*WIDTH))
  - out_valid <= 1 in that case.
  - The previous product1 has already been consumed at that point, so accumulation always chains on the last delivered result.
- Output drain: if the final stage holds a bubble and stall is low, out_valid <= 0 and product1 holds its value, keeping the accumulator intact.
- Accumulate boundary cases:
  - Accumulator overflow wraps silently; no saturation or flag.
  - op_acc=1 on the first beat after reset adds to 0.
  - Mixed signed and unsigned beats may accumulate; the add is plain modulo-2^(2*WIDTH).
- Simultaneous events: in_valid & out_valid & out_ready in the same cycle is legal. Accept and deliver both occur, and occupancy is unchanged.
- Reset mid-operation:
  - RST flushes all in-flight beats and clears the accumulator on that edge. No in-flight beat is ever delivered.
  - in_ready is 1 in the cycle after reset.
  - If RST and in_valid are both high on the same edge, the beat is not accepted.
- Ordering: results are delivered strictly in accept order. No beat is dropped or duplicated under any out_ready pattern.

Test Plan:
- WIDTH=32, STAGES=2, unsigned 0xFFFFFFFF*0xFFFFFFFF accepted at edge k, out_ready=1 -> out_valid first high after edge k+3, product1=0xFFFFFFFE00000001.
- Signed beats, back-to-back:
  - -1*-1 -> 0x0000000000000001
  - 0x80000000*0x80000000 -> 0x4000000000000000
  - -1*2 -> 0xFFFFFFFFFFFFFFFE
  - Results on three consecutive cycles.
- Accumulate chain, unsigned:
  - 3*4 (acc=0) -> 12
  - 5*6 (acc=1) -> 42
  - 7*8 (acc=1) -> 98
  - Wrap check: 0xFFFFFFFF^2 (acc=0) then 0xFFFFFFFF^2 (acc=1) -> 0xFFFFFFFC00000002.
- Backpressure: stream 6 beats (1*1..6*6) with out_ready=0 for cycles 4-9 -> in_ready low while stalled, no beat lost or reordered, outputs 1,4,9,16,25,36.
- Simultaneous accept/deliver at full occupancy with random out_ready (50%) over 200 beats -> scoreboard match, in_ready = ~(out_valid & ~out_ready) every cycle.
- RST asserted with 2 beats in flight and product1=98 -> after the edge out_valid=0 and no further results; next beat 2*3 with acc=1 yields 6, not 104.
